// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared 16x8 data memory: CPU control unit vs host/debug loader.
// Define MEMARB_RR_EN to arbitrate simultaneous idle requests round-robin instead of CPU-first.
module mem_port_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_ctrl,
    input  logic              rst_ctrl,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              busy
);

    // State encoding doubles as the owner code, so owner comes straight from a flop.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_HOST = 2'b10
    } state_t;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       grant_nxt;
    req_id_t    grant_id;
    req_id_t    idle_pick;
    req_id_t    own_id, oth_id;
    logic       cpu_eff, host_eff, own_eff, oth_eff, any_gnt;
    logic       rd_pend;
    req_id_t    rd_tag;

    function automatic state_t own_state(input req_id_t id);
        return (id == REQ_HOST) ? OWN_HOST : OWN_CPU;
    endfunction

    // A request is ignored in the cycle its own grant is showing.
    assign cpu_eff  = cpu_req  & ~cpu_gnt;
    assign host_eff = host_req & ~host_gnt;
    assign any_gnt  = cpu_gnt | host_gnt;

    assign own_id  = (state == OWN_HOST) ? REQ_HOST : REQ_CPU;
    assign oth_id  = (state == OWN_HOST) ? REQ_CPU  : REQ_HOST;
    assign own_eff = (own_id == REQ_HOST) ? host_eff : cpu_eff;
    assign oth_eff = (oth_id == REQ_HOST) ? host_eff : cpu_eff;
    assign owner   = state;

`ifdef MEMARB_RR_EN
    req_id_t last_owner;
    assign idle_pick = (last_owner == REQ_HOST) ? REQ_CPU : REQ_HOST;
`else
    assign idle_pick = REQ_CPU;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_nxt = state;
        burst_nxt = burst_cnt;
        grant_nxt = 1'b0;
        grant_id  = REQ_CPU;
        unique case (state)
            IDLE: begin
                if (cpu_eff || host_eff) begin
                    grant_nxt = 1'b1;
                    if (cpu_eff && host_eff) grant_id = idle_pick;
                    else                     grant_id = host_eff ? REQ_HOST : REQ_CPU;
                    state_nxt = own_state(grant_id);
                    burst_nxt = 4'd1;
                end
            end
            default: begin
                // Decisions in an OWN state are taken only between grants.
                if (!any_gnt) begin
                    if (own_eff && (burst_cnt < BURST_LIM || !oth_eff)) begin
                        grant_nxt = 1'b1;
                        grant_id  = own_id;
                        burst_nxt = (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;
                    end else if (oth_eff) begin
                        grant_nxt = 1'b1;
                        grant_id  = oth_id;
                        state_nxt = own_state(oth_id);
                        burst_nxt = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        burst_nxt = 4'd0;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            state       <= IDLE;
            burst_cnt   <= 4'd0;
            busy        <= 1'b0;
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            mem_adr     <= '0;
            mem_wr      <= 1'b0;
            mem_wdata   <= '0;
            rd_pend     <= 1'b0;
            rd_tag      <= REQ_CPU;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
`ifdef MEMARB_RR_EN
            last_owner  <= REQ_HOST;
`endif
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            busy      <= (state_nxt != IDLE);
            cpu_gnt   <= grant_nxt && (grant_id == REQ_CPU);
            host_gnt  <= grant_nxt && (grant_id == REQ_HOST);
            mem_wr    <= 1'b0;
            if (grant_nxt) begin
                mem_adr   <= (grant_id == REQ_HOST) ? host_addr  : cpu_addr;
                mem_wr    <= (grant_id == REQ_HOST) ? host_we    : cpu_we;
                mem_wdata <= (grant_id == REQ_HOST) ? host_wdata : cpu_wdata;
`ifdef MEMARB_RR_EN
                last_owner <= grant_id;
`endif
            end
            // Read pipeline carries the requester tag so data returns to the right port.
            rd_pend     <= any_gnt & ~mem_wr;
            rd_tag      <= host_gnt ? REQ_HOST : REQ_CPU;
            cpu_rvalid  <= rd_pend && (rd_tag == REQ_CPU);
            host_rvalid <= rd_pend && (rd_tag == REQ_HOST);
            if (rd_pend && rd_tag == REQ_CPU)  cpu_rdata  <= mem_rdata;
            if (rd_pend && rd_tag == REQ_HOST) host_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven vectors plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int MAX_BURST = 4;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic              clk_ctrl = 1'b0;
    logic              rst_ctrl = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req = 1'b0, host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_gnt, host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] mem_adr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        owner;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_ctrl = ~clk_ctrl;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk_ctrl(clk_ctrl), .rst_ctrl(rst_ctrl),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_adr(mem_adr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    // Synchronous-read memory model; contents reload while reset is held.
    logic [7:0] mem [16];
    always @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 8'hA5 : 8'(8'h40 + i);
        end else if (mem_wr) begin
            mem[mem_adr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_adr];
    end

    typedef struct {
        logic       cr, cw; logic [3:0] ca; logic [7:0] cd;
        logic       hr, hw; logic [3:0] ha; logic [7:0] hd;
        logic       cg, hg, crv; logic [7:0] crd; logic hrv;
        logic [1:0] own; logic mwr; logic [3:0] madr; logic [7:0] mwd;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ctrl);
        @(negedge clk_ctrl);
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [3:0] ca, input logic [7:0] cd,
                         input logic hr, input logic hw, input logic [3:0] ha, input logic [7:0] hd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    task automatic check_ports(input string tag, input logic cg, input logic hg, input logic [1:0] own);
        check({tag, " cpu_gnt"}, 32'(cpu_gnt), 32'(cg));
        check({tag, " host_gnt"}, 32'(host_gnt), 32'(hg));
        check({tag, " owner"}, 32'(owner), 32'(own));
        check({tag, " busy"}, 32'(busy), 32'(own != 2'b00));
    endtask

    task automatic do_reset();
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        rst_ctrl = 1'b1;
        tick();
        tick();
        rst_ctrl = 1'b0;
        tick();
    endtask

    // Expected owner of the g-th grant when both sides request continuously.
    function automatic logic burst_host(input int g);
        return ((g / MAX_BURST) % 2) == 1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          cr cw ca     cd     hr hw ha     hd     cg hg crv crd    hrv own    mwr madr  mwd
        vecs[0]  = '{H, L, 4'h3, 8'h00, L, L, 4'h0, 8'h00, H, L, L, 8'h00, L, 2'b01, L, 4'h3, 8'h00};
        vecs[1]  = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b01, L, 4'h3, 8'h00};
        vecs[2]  = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, H, 8'hA5, L, 2'b00, L, 4'h3, 8'h00};
        vecs[3]  = '{L, L, 4'h0, 8'h00, H, H, 4'h9, 8'h5C, L, H, L, 8'h00, L, 2'b10, H, 4'h9, 8'h5C};
        vecs[4]  = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b10, L, 4'h9, 8'h00};
        vecs[5]  = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b00, L, 4'h9, 8'h00};
        vecs[6]  = '{H, L, 4'h9, 8'h00, L, L, 4'h0, 8'h00, H, L, L, 8'h00, L, 2'b01, L, 4'h9, 8'h00};
        vecs[7]  = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b01, L, 4'h9, 8'h00};
        vecs[8]  = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, H, 8'h5C, L, 2'b00, L, 4'h9, 8'h00};
        vecs[9]  = '{H, L, 4'h1, 8'h00, L, L, 4'h0, 8'h00, H, L, L, 8'h00, L, 2'b01, L, 4'h1, 8'h00};
        vecs[10] = '{H, L, 4'h2, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b01, L, 4'h1, 8'h00};
        vecs[11] = '{H, L, 4'h2, 8'h00, L, L, 4'h0, 8'h00, H, L, H, 8'h41, L, 2'b01, L, 4'h2, 8'h00};
        vecs[12] = '{H, L, 4'h7, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b01, L, 4'h2, 8'h00};
        vecs[13] = '{H, L, 4'h7, 8'h00, L, L, 4'h0, 8'h00, H, L, H, 8'h42, L, 2'b01, L, 4'h7, 8'h00};
        vecs[14] = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b01, L, 4'h7, 8'h00};
        vecs[15] = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, H, 8'h47, L, 2'b00, L, 4'h7, 8'h00};
        vecs[16] = '{L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00, L, L, L, 8'h00, L, 2'b00, L, 4'h7, 8'h00};

        // Reset state, observed while reset is still asserted.
        @(negedge clk_ctrl);
        @(negedge clk_ctrl);
        check_ports("reset", L, L, 2'b00);
        check("reset mem_wr", 32'(mem_wr), 32'h0);
        check("reset mem_adr", 32'(mem_adr), 32'h0);
        check("reset mem_wdata", 32'(mem_wdata), 32'h0);
        check("reset rvalid", 32'({cpu_rvalid, host_rvalid}), 32'h0);
        check("reset rdata", 32'({cpu_rdata, host_rdata}), 32'h0);
        rst_ctrl = 1'b0;
        tick();

        // CPU read, host write then CPU read, CPU back-to-back reads.
        for (int i = 0; i < 17; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].hr, vecs[i].hw, vecs[i].ha, vecs[i].hd);
            tick();
            check_ports(t, vecs[i].cg, vecs[i].hg, vecs[i].own);
            check({t, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(vecs[i].crv));
            check({t, " host_rvalid"}, 32'(host_rvalid), 32'(vecs[i].hrv));
            check({t, " mem_wr"}, 32'(mem_wr), 32'(vecs[i].mwr));
            check({t, " mem_adr"}, 32'(mem_adr), 32'(vecs[i].madr));
            if (vecs[i].crv) check({t, " cpu_rdata"}, 32'(cpu_rdata), 32'(vecs[i].crd));
            if (vecs[i].mwr) check({t, " mem_wdata"}, 32'(mem_wdata), 32'(vecs[i].mwd));
        end

        // Both requesting continuously from a fresh reset: bursts of MAX_BURST alternate.
        do_reset();
        drive(H, L, 4'h1, 8'h00, H, L, 4'h2, 8'h00);
        for (int k = 0; k < 20; k++) begin
            string t;
            logic  gk, hk, crv_e, hrv_e;
            t  = $sformatf("burst%0d", k);
            gk = (k % 2) == 0;
            hk = burst_host(k / 2);
            crv_e = (k >= 2) && gk && !burst_host((k - 2) / 2);
            hrv_e = (k >= 2) && gk &&  burst_host((k - 2) / 2);
            tick();
            check_ports(t, gk && !hk, gk && hk, hk ? 2'b10 : 2'b01);
            check({t, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(crv_e));
            check({t, " host_rvalid"}, 32'(host_rvalid), 32'(hrv_e));
            if (crv_e) check({t, " cpu_rdata"}, 32'(cpu_rdata), 32'h41);
            if (hrv_e) check({t, " host_rdata"}, 32'(host_rdata), 32'h42);
        end
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick(); tick(); tick();
        check_ports("burst drain", L, L, 2'b00);

        // Owner drop: CPU owns for two grants, then releases to the waiting host.
        drive(H, L, 4'h4, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        check_ports("drop g1", H, L, 2'b01);
        check("drop g1 burst_cnt", 32'(dut.burst_cnt), 32'h1);
        drive(H, L, 4'h4, 8'h00, H, L, 4'h5, 8'h00);
        tick();
        check_ports("drop gap1", L, L, 2'b01);
        tick();
        check_ports("drop g2", H, L, 2'b01);
        check("drop g2 burst_cnt", 32'(dut.burst_cnt), 32'h2);
        drive(L, L, 4'h0, 8'h00, H, L, 4'h5, 8'h00);
        tick();
        check_ports("drop gap2", L, L, 2'b01);
        tick();
        check_ports("drop host", L, H, 2'b10);
        check("drop host burst_cnt", 32'(dut.burst_cnt), 32'h1);
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        tick();
        check_ports("drop idle", L, L, 2'b00);
        check("drop host_rvalid", 32'(host_rvalid), 32'h1);
        check("drop host_rdata", 32'(host_rdata), 32'h45);

        // Reset mid-write: outputs clear without a clock edge.
        drive(H, H, 4'hC, 8'h77, L, L, 4'h0, 8'h00);
        tick();
        check("rstw mem_wr before", 32'(mem_wr), 32'h1);
        rst_ctrl = 1'b1;
        #1;
        check_ports("rstw async", L, L, 2'b00);
        check("rstw mem_wr async", 32'(mem_wr), 32'h0);
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        rst_ctrl = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstw post%0d rvalid", k), 32'({cpu_rvalid, host_rvalid}), 32'h0);
        end

        // Reset with a read in flight: that read never returns.
        drive(H, L, 4'h3, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        check_ports("rstr grant", H, L, 2'b01);
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        rst_ctrl = 1'b1;
        #1;
        check("rstr rvalid async", 32'(cpu_rvalid), 32'h0);
        tick();
        rst_ctrl = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("rstr post%0d rvalid", k), 32'({cpu_rvalid, host_rvalid}), 32'h0);
        end

        // First request after reset proceeds normally.
        drive(H, L, 4'h3, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        check_ports("post grant", H, L, 2'b01);
        check("post mem_adr", 32'(mem_adr), 32'h3);
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        tick();
        check("post cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("post cpu_rdata", 32'(cpu_rdata), 32'hA5);

        // Idle arbitration after a host-only access, then after a CPU-only access.
        drive(L, L, 4'h0, 8'h00, H, L, 4'h5, 8'h00);
        tick();
        check_ports("arb host only", L, H, 2'b10);
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick(); tick();
        drive(H, L, 4'h6, 8'h00, H, L, 4'h8, 8'h00);
        tick();
        check_ports("arb after host", H, L, 2'b01);
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick(); tick(); tick();
        drive(H, L, 4'h6, 8'h00, L, L, 4'h0, 8'h00);
        tick();
        check_ports("arb cpu only", H, L, 2'b01);
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick(); tick();
        drive(H, L, 4'h6, 8'h00, H, L, 4'h8, 8'h00);
        tick();
`ifdef MEMARB_RR_EN
        check_ports("arb after cpu", L, H, 2'b10);
`else
        check_ports("arb after cpu", H, L, 2'b01);
`endif
        drive(L, L, 4'h0, 8'h00, L, L, 4'h0, 8'h00);
        tick(); tick(); tick();
        check_ports("final idle", L, L, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16x8 data memory (the one addressed by mmadr/mmwr) between two requesters: the CPU control unit and an external host/debug loader.
- Arbitrates access, drives the memory's address, write-enable and write-data, and returns read data to the winner with a valid strobe.
- Sits between the control unit, the host port and the datapath memory.
- Bounds ownership so that neither requester can starve the other.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 8, memory data width
MAX_BURST, 4, max consecutive grants to one owner while the other requester is waiting (range 1..15)

Ports:
clk_ctrl  in  1  clock, rising edge
rst_ctrl  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU access request; addr/we/wdata must be held stable while req=1 and gnt=0
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse; the access is accepted in this cycle
cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
cpu_rdata  out  DATA_W  read data
host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host equivalents of the CPU inputs
host_gnt, host_rvalid, host_rdata  out  1/1/DATA_W  host equivalents of the CPU outputs
mem_adr  out  ADDR_W  memory address
mem_wr  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_adr is presented
owner  out  2  00=none, 01=CPU, 10=host
busy  out  1  1 when owner != 00

Behaviour:
- Reset: rst_ctrl is asynchronous and active-high. It immediately clears all outputs to 0 (gnt, rvalid, rdata, mem_adr, mem_wr, mem_wdata, owner, busy), the burst counter, and last_owner. State goes to IDLE.
- All outputs are registered.
- A reset mid-access drops mem_wr at once. An aborted read never produces an rvalid.
- States are IDLE, OWN_CPU and OWN_HOST.
- Effective request: a requester's req is ignored in any cycle where its own gnt=1. Consequences:
  - one requester can be granted at most every 2nd cycle;
  - a requester may keep req high for back-to-back accesses;
  - a requester that has seen its gnt must present its next address by the following edge.
- IDLE:
  - No effective request: stay in IDLE.
  - Exactly one effective request: go to that requester's OWN state.
  - Both requesting: the CPU wins (fixed priority; see Optional Feature for round-robin).
- Grant cycle (the cycle after the edge that selects the winner):
  - gnt=1;
  - mem_adr = winner's addr;
  - mem_wr = winner's we;
  - mem_wdata = winner's wdata.
- Non-grant cycles: mem_wr=0 and mem_adr holds its last value.
- Read latency: request sampled at edge E, gnt during cycle E..E+1, mem_rdata valid in the following cycle. mem_rdata is registered into rdata with rvalid=1 one cycle later. From sampling edge to rvalid is 3 cycles.
- Writes produce no rvalid.
- rdata holds its value until the next read by the same requester.
- OWN_x, on a non-gnt cycle:
  - owner still requesting, and (burst_cnt < MAX_BURST or other idle): grant the owner again and increment burst_cnt, saturating at 15;
  - owner requesting, other requesting, and burst_cnt = MAX_BURST: switch to OWN_other, reset burst_cnt to 1, and grant the other;
  - owner not requesting, other requesting: switch to OWN_other with a grant and burst_cnt=1;
  - neither requesting: go to IDLE with burst_cnt=0.
- burst_cnt counts consecutive grants to the current owner. The first grant sets it to 1.
- The read pipeline stage is tagged with the requester, so rvalid always reaches the correct port even across an ownership switch.
- Address wrap: none. ADDR_W bits are passed through unchanged.

Optional Feature:
- Macro: MEMARB_RR_EN.
- When defined: in IDLE with both requesting, the winner is the requester that is not last_owner. last_owner updates on every grant and resets to the host, so the CPU wins first.
- When undefined: fixed CPU priority in IDLE. The burst limit still applies in the OWN states.

Test Plan:
- CPU read: cpu_req=1, we=0, addr=4'h3, memory[3]=8'hA5.
  - Required: cpu_gnt exactly 1 cycle after the sampling edge; cpu_rvalid=1 with cpu_rdata=8'hA5 at sampling edge + 3; host outputs stay 0.
- Host write then CPU read: host writes 8'h5C to addr 4'h9, then the CPU reads addr 4'h9.
  - Required: mem_wr=1 for exactly one cycle with mem_adr=9 and mem_wdata=5C; the CPU later gets rdata=5C; owner sequence 10 -> 00 -> 01.
- Simultaneous request from IDLE with MAX_BURST=4, both holding req continuously:
  - without MEMARB_RR_EN: 4 CPU grants, then 4 host grants, alternating thereafter;
  - with MEMARB_RR_EN from reset: the CPU wins first; after a host-only access, a later simultaneous request goes to the CPU.
- Back-to-back from one requester: cpu_req held high across 3 addresses with the host idle.
  - Required: grants every 2nd cycle, 3 grants total, burst_cnt never forces a switch, then IDLE.
- Reset mid-write: assert rst_ctrl while mem_wr=1.
  - Required: mem_wr, gnt and owner go to 0 immediately without waiting for a clock; no rvalid after release; the first post-reset request is granted normally.
- Owner drop: CPU owns, host requests, CPU drops req after 2 grants.
  - Required: the host is granted on the next non-gnt cycle with burst_cnt=1; owner=10.
